// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: slewed-duty motor PWM driven by ramp-stage requests.
// Ports: clk/rst_n, ena, out_30/50/100 in; pwm_out, duty[6:0], at_target, fault out.
module motor_pwm_driver #(
  parameter int PWM_PERIOD = 100,
  parameter int STEP_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       out_30,
  input  logic       out_50,
  input  logic       out_100,
  output logic       pwm_out,
  output logic [6:0] duty,
  output logic       at_target,
  output logic       fault
);

  localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PWM_PERIOD - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN,
    HOLD,
    FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    duty_q, duty_d;
  logic [6:0]    app_q, app_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic          pwm_q, pwm_d;
  logic          at_tgt_q, at_tgt_d;

  logic          step;
  logic          bad;
  logic [6:0]    target;
  state_t        settle;

  // Bit order of the synchronised bus: {out_100, out_50, out_30}.
  function automatic logic [6:0] tgt_of(input logic [2:0] s);
    logic [6:0] t;
    t = 7'd0;
    unique case (1'b1)
      (s == 3'b001): t = 7'd30;
      (s == 3'b010): t = 7'd50;
      (s == 3'b100): t = 7'd100;
      default:       t = 7'd0;
    endcase
    return t;
  endfunction

  function automatic logic bad_of(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    app_d    = app_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;
    sync1_d  = sync1_q;
    sync2_d  = sync2_q;
    at_tgt_d = at_tgt_q;
    pwm_d    = 1'b0;
    step     = (presc_q == PRE_MAX);
    target   = tgt_of(sync2_q);
    bad      = bad_of(sync2_q);
    settle   = (target == 7'd0) ? IDLE : HOLD;

    if (ena) begin
      sync1_d = {out_100, out_50, out_30};
      sync2_d = sync1_q;

      unique case (state_q)
        IDLE, HOLD: begin
          if (bad) state_d = FAULT;
          else if (target > duty_q) state_d = RAMP_UP;
          else if (target < duty_q) state_d = RAMP_DOWN;
          else state_d = settle;
        end
        RAMP_UP: begin
          if (bad) state_d = FAULT;
          else if (target < duty_q) state_d = RAMP_DOWN;
          else if (target == duty_q) state_d = settle;
          else if (step) begin
            duty_d = duty_q + 7'd1;
            if (duty_d == target) state_d = settle;
          end
        end
        RAMP_DOWN: begin
          if (bad) state_d = FAULT;
          else if (target > duty_q) state_d = RAMP_UP;
          else if (target == duty_q) state_d = settle;
          else if (step) begin
            duty_d = duty_q - 7'd1;
            if (duty_d == target) state_d = settle;
          end
        end
        FAULT: begin
          if (sync2_q == 3'b000) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // Prescaler restarts on any state entry and only runs while ramping.
      if (state_d != state_q) presc_d = '0;
      else if (state_q == RAMP_UP || state_q == RAMP_DOWN)
        presc_d = step ? '0 : presc_q + PW'(1);
      else presc_d = '0;

      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        app_d = duty_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end

      // Fault bypasses the wrap-aligned load so the output dies at once.
      if (state_d == FAULT) begin
        duty_d = 7'd0;
        app_d  = 7'd0;
      end

      pwm_d = (32'(cnt_d) < 32'(app_d));

      // Registered so it tracks next-cycle state and target.
      at_tgt_d = (state_d == IDLE || state_d == HOLD)
              && (duty_d == tgt_of(sync1_q))
              && !bad_of(sync1_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      duty_q   <= 7'd0;
      app_q    <= 7'd0;
      cnt_q    <= '0;
      presc_q  <= '0;
      sync1_q  <= 3'b000;
      sync2_q  <= 3'b000;
      pwm_q    <= 1'b0;
      at_tgt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      app_q    <= app_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      pwm_q    <= pwm_d;
      at_tgt_q <= at_tgt_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign duty      = duty_q;
  assign at_target = at_tgt_q;
  assign fault     = (state_q == FAULT);

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver: randomized and directed bench for motor_pwm_driver.
// Expected values come from a duty-slew model built on the requirement rules.
module tb_motor_pwm_driver;

  localparam int PER  = 100;
  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       out_30;
  logic       out_50;
  logic       out_100;
  logic       pwm_out;
  logic [6:0] duty;
  logic       at_target;
  logic       fault;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  motor_pwm_driver #(
    .PWM_PERIOD(PER),
    .STEP_DIV  (STEP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .out_30   (out_30),
    .out_50   (out_50),
    .out_100  (out_100),
    .pwm_out  (pwm_out),
    .duty     (duty),
    .at_target(at_target),
    .fault    (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic a, input logic b, input logic c);
    out_30  = a;
    out_50  = b;
    out_100 = c;
  endtask

  function automatic int approach(input int d, input int t, input int n);
    if (d < t) return (d + n < t) ? d + n : t;
    return (d - n > t) ? d - n : t;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    n_chk++;
    if (duty !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_duty: got %0d expected 0", duty);
    end
    n_chk++;
    if (pwm_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pwm: got %b expected 0", pwm_out);
    end
    n_chk++;
    if (at_target !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_at_target: got %b expected 0", at_target);
    end
    n_chk++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fault: got %b expected 0", fault);
    end
    #3 rst_n = 1'b1;
    repeat (3) tick();
    n_chk++;
    if (at_target !== 1'b1 || duty !== 7'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got at_target=%b duty=%0d expected 1/0",
               at_target, duty);
    end
  endtask

  task automatic test_ramp(input string nm, input logic a, input logic b,
                           input logic c, input int tgt, input int tmin,
                           input int tmax);
    int prev, first, lastc, dir, bad_step, bad_gap;
    bit seen;
    prev     = int'(duty);
    dir      = (tgt > prev) ? 1 : -1;
    first    = -1;
    lastc    = 0;
    seen     = 1'b0;
    bad_step = 0;
    bad_gap  = 0;
    set_in(a, b, c);
    for (int i = 1; i <= tmax + 20; i++) begin
      tick();
      if (int'(duty) != prev) begin
        if (int'(duty) != prev + dir) bad_step++;
        if (seen && (i - lastc) != STEP) bad_gap++;
        seen  = 1'b1;
        lastc = i;
        prev  = int'(duty);
      end
      if (int'(duty) == tgt) begin
        first = i;
        break;
      end
    end
    n_chk++;
    if (first < tmin || first > tmax) begin
      n_fail++;
      $display("FAIL %s_arrival: got cycle %0d expected %0d..%0d",
               nm, first, tmin, tmax);
    end
    n_chk++;
    if (bad_step != 0) begin
      n_fail++;
      $display("FAIL %s_step_size: got %0d bad steps expected 0", nm, bad_step);
    end
    n_chk++;
    if (bad_gap != 0) begin
      n_fail++;
      $display("FAIL %s_step_gap: got %0d bad gaps expected 0", nm, bad_gap);
    end
    n_chk++;
    if (at_target !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_at_target: got %b expected 1", nm, at_target);
    end
    repeat (10) tick();
    n_chk++;
    if (int'(duty) != tgt) begin
      n_fail++;
      $display("FAIL %s_hold: got %0d expected %0d", nm, duty, tgt);
    end
  endtask

  task automatic test_pwm_ratio(input string nm, input int window,
                                input int exp_high);
    int highs;
    highs = 0;
    repeat (110) tick();
    for (int i = 0; i < window; i++) begin
      tick();
      if (pwm_out === 1'b1) highs++;
    end
    n_chk++;
    if (highs != exp_high) begin
      n_fail++;
      $display("FAIL %s_pwm_high: got %0d of %0d expected %0d",
               nm, highs, window, exp_high);
    end
  endtask

  task automatic test_fault();
    int got;
    test_ramp("up50", 1'b0, 1'b1, 1'b0, 50, 200, 204);
    set_in(1'b1, 1'b0, 1'b1);
    got = -1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (fault === 1'b1) begin
        got = i;
        break;
      end
    end
    n_chk++;
    if (got < 0) begin
      n_fail++;
      $display("FAIL fault_entry: got fault=%b after 3 cycles expected 1", fault);
    end
    n_chk++;
    if (pwm_out !== 1'b0 || duty !== 7'd0) begin
      n_fail++;
      $display("FAIL fault_outputs: got pwm=%b duty=%0d expected 0/0",
               pwm_out, duty);
    end
    repeat (5) tick();
    n_chk++;
    if (fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_sticky: got %b expected 1", fault);
    end
    set_in(1'b0, 1'b0, 1'b0);
    got = -1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (fault === 1'b0) begin
        got = i;
        break;
      end
    end
    n_chk++;
    if (got < 0) begin
      n_fail++;
      $display("FAIL fault_exit: got fault=%b expected 0", fault);
    end
    tick();
    n_chk++;
    if (duty !== 7'd0 || at_target !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_idle: got duty=%0d at_target=%b expected 0/1",
               duty, at_target);
    end
  endtask

  task automatic test_retarget();
    int got, mx;
    set_in(1'b0, 1'b0, 1'b1);
    got = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (duty == 7'd40) begin
        got = i;
        break;
      end
    end
    n_chk++;
    if (got < 0) begin
      n_fail++;
      $display("FAIL retarget_reach40: got duty %0d expected 40", duty);
    end
    set_in(1'b0, 1'b1, 1'b0);
    mx = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (int'(duty) > mx) mx = int'(duty);
    end
    n_chk++;
    if (mx != 50) begin
      n_fail++;
      $display("FAIL retarget_peak: got %0d expected 50", mx);
    end
    n_chk++;
    if (duty !== 7'd50 || at_target !== 1'b1) begin
      n_fail++;
      $display("FAIL retarget_final: got duty=%0d at_target=%b expected 50/1",
               duty, at_target);
    end
  endtask

  task automatic test_async_reset();
    int got;
    set_in(1'b0, 1'b0, 1'b1);
    got = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (duty == 7'd60) begin
        got = i;
        break;
      end
    end
    n_chk++;
    if (got < 0) begin
      n_fail++;
      $display("FAIL arst_reach60: got duty %0d expected 60", duty);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (duty !== 7'd0 || pwm_out !== 1'b0 || at_target !== 1'b0
        || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_outputs: got duty=%0d pwm=%b at=%b flt=%b expected 0",
               duty, pwm_out, at_target, fault);
    end
    #2 rst_n = 1'b1;
    repeat (2) tick();
    n_chk++;
    if (duty !== 7'd0) begin
      n_fail++;
      $display("FAIL arst_sync_fill: got %0d expected 0", duty);
    end
    repeat (38) tick();
    n_chk++;
    if (duty < 7'd8 || duty > 7'd10) begin
      n_fail++;
      $display("FAIL arst_reramp: got %0d expected 8..10", duty);
    end
  endtask

  task automatic test_ena();
    int d0, bad_d, bad_p, got;
    d0    = int'(duty);
    bad_d = 0;
    bad_p = 0;
    ena   = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (int'(duty) != d0) bad_d++;
      if (pwm_out !== 1'b0) bad_p++;
    end
    n_chk++;
    if (bad_d != 0) begin
      n_fail++;
      $display("FAIL ena_freeze_duty: got %0d moves expected 0", bad_d);
    end
    n_chk++;
    if (bad_p != 0) begin
      n_fail++;
      $display("FAIL ena_pwm_low: got %0d high cycles expected 0", bad_p);
    end
    ena = 1'b1;
    got = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (int'(duty) == d0 + 1) begin
        got = i;
        break;
      end
    end
    n_chk++;
    if (got < 0) begin
      n_fail++;
      $display("FAIL ena_resume: got duty %0d expected %0d", duty, d0 + 1);
    end
  endtask

  task automatic test_random();
    int tbl[4];
    int lo, hi, tgt, ptgt, len, prev, jumps, nmin, nmax;
    int a1, a2, a3, a4;
    tbl[0] = 0;
    tbl[1] = 30;
    tbl[2] = 50;
    tbl[3] = 100;
    set_in(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    repeat (5) tick();
    lo    = 0;
    hi    = 0;
    ptgt  = 0;
    jumps = 0;
    prev  = int'(duty);
    for (int s = 0; s < 12; s++) begin
      int k;
      k   = int'($urandom_range(0, 3));
      tgt = tbl[k];
      len = int'($urandom_range(20, 300));
      set_in(k == 1, k == 2, k == 3);
      for (int c = 1; c <= len; c++) begin
        tick();
        if (int'(duty) - prev > 1 || prev - int'(duty) > 1) jumps++;
        prev = int'(duty);
        if (c == 2) begin
          if (s > 0) begin
            n_chk++;
            if (int'(duty) < lo || int'(duty) > hi) begin
              n_fail++;
              $display("FAIL rand_seg%0d: got %0d expected %0d..%0d tgt %0d",
                       s - 1, duty, lo, hi, ptgt);
            end
          end
          nmin = (len - 1) / STEP;
          nmax = (len + STEP - 1) / STEP;
          a1 = approach(lo, tgt, nmin);
          a2 = approach(lo, tgt, nmax);
          a3 = approach(hi, tgt, nmin);
          a4 = approach(hi, tgt, nmax);
          lo = a1;
          if (a2 < lo) lo = a2;
          if (a3 < lo) lo = a3;
          if (a4 < lo) lo = a4;
          hi = a1;
          if (a2 > hi) hi = a2;
          if (a3 > hi) hi = a3;
          if (a4 > hi) hi = a4;
          ptgt = tgt;
        end
      end
    end
    repeat (2) tick();
    n_chk++;
    if (int'(duty) < lo || int'(duty) > hi) begin
      n_fail++;
      $display("FAIL rand_last: got %0d expected %0d..%0d", duty, lo, hi);
    end
    n_chk++;
    if (jumps != 0) begin
      n_fail++;
      $display("FAIL rand_slew: got %0d jumps expected 0", jumps);
    end
    if (lo == tgt && hi == tgt) begin
      n_chk++;
      if (at_target !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_at_target: got %b expected 1", at_target);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp("up30", 1'b1, 1'b0, 1'b0, 30, 122, 124);
    test_pwm_ratio("duty30", PER, 30);
    test_ramp("up100", 1'b0, 1'b0, 1'b1, 100, 280, 284);
    test_pwm_ratio("duty100", 2 * PER, 2 * PER);
    test_ramp("down0", 1'b0, 1'b0, 1'b0, 0, 400, 404);
    test_pwm_ratio("duty0", 2 * PER, 0);
    test_fault();
    test_retarget();
    test_async_reset();
    test_ena();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_pwm_driver.md
MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

Interface
REQ-001 The block SHALL have parameter PWM_PERIOD, default 100, meaning PWM counter period in clk cycles; duty resolution is 1 count = 1 %.
REQ-002 The block SHALL have parameter STEP_DIV, default 4, meaning clk cycles per 1 % duty slew step (>=1).
REQ-003 The block SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port ena  input  1  global enable; 0 freezes all state and forces pwm_out low.
REQ-006 The block SHALL have port out_30  input  1  ramp-stage request, 30 % target duty, from the upstream ramp FSM.
REQ-007 The block SHALL have port out_50  input  1  ramp-stage request, 50 % target duty.
REQ-008 The block SHALL have port out_100  input  1  ramp-stage request, 100 % target duty.
REQ-009 The block SHALL have port pwm_out  output  1  motor drive PWM, registered.
REQ-010 The block SHALL have port duty  output  7  current slewed duty, 0..100.
REQ-011 The block SHALL have port at_target  output  1  high while duty equals the decoded target and state is HOLD or IDLE.
REQ-012 The block SHALL have port fault  output  1  high while in FAULT state.

Function
REQ-013 Target decode SHALL be: none high -> 0; only out_30 -> 30; only out_50 -> 50; only out_100 -> 100; two or more high -> illegal.
REQ-014 Stage inputs SHALL pass through a 2-flop synchroniser before decode; decode latency is 2 cycles.
REQ-015 The FSM SHALL have states IDLE (duty 0, target 0), RAMP_UP, RAMP_DOWN, HOLD and FAULT.
REQ-016 From IDLE or HOLD, target > duty SHALL go to RAMP_UP, target < duty to RAMP_DOWN, and equality SHALL remain in or enter HOLD (IDLE when 0).
REQ-017 In RAMP_UP/RAMP_DOWN, duty SHALL change by exactly 1 every STEP_DIV enabled cycles; the step prescaler SHALL clear on every state entry.
REQ-018 A target change mid-ramp SHALL re-evaluate direction on the next cycle without resetting duty; duty SHALL never overshoot the target.
REQ-019 Reaching the target SHALL enter HOLD (or IDLE if target 0) in the same cycle the final step is taken.
REQ-020 An illegal decode from any state SHALL enter FAULT next cycle, forcing duty to 0 and pwm_out low that same cycle (no slew).
REQ-021 FAULT SHALL exit to IDLE only after all three synchronised inputs are low for one cycle.
REQ-022 The PWM counter SHALL run 0..PWM_PERIOD-1 and wrap to 0.
REQ-023 pwm_out SHALL be registered as (counter < duty_applied).
REQ-024 duty_applied SHALL load from duty only at counter wrap (glitch-free), except that FAULT SHALL zero it immediately.
REQ-025 duty = 100 SHALL give constant high and duty = 0 SHALL give constant low, with no single-cycle pulses at wrap.
REQ-026 When ena = 0, the counter, prescaler, FSM and duty SHALL hold and pwm_out SHALL be 0; on re-enable they SHALL resume from held values.

Reset
REQ-027 rst_n low SHALL asynchronously clear state to IDLE, duty, duty_applied, counter, prescaler and synchronisers to 0, and drive pwm_out, at_target and fault to 0.
REQ-028 Reset mid-ramp SHALL abandon the ramp; after release the block SHALL start from IDLE and re-ramp from 0.
REQ-029 Release of rst_n SHALL be usable asynchronously; the first state change SHALL occur no earlier than the third clk edge after release (synchroniser fill).

Verification
REQ-030 Reset then out_30 held -> duty reaches 30 after 2+30*4=122 cycles; state HOLD; at_target=1; pwm_out high 30 of every 100 cycles.
REQ-031 From HOLD at 30, switch to out_100 -> duty ramps 30->100 in 280 cycles; pwm_out constant high thereafter with no low cycle at wrap.
REQ-032 From 100, drop all inputs -> RAMP_DOWN to 0 in 400 cycles; IDLE; pwm_out constant low.
REQ-033 At duty 50, assert out_30 and out_100 together -> fault=1 and pwm_out=0 within 3 cycles; duty=0; release all inputs -> IDLE, fault=0.
REQ-034 Mid-ramp at duty 40 toward 100, switch to out_50 -> continues up, stops exactly at 50, no overshoot.
REQ-035 Mid-ramp, pulse rst_n low for less than one cycle -> all outputs 0 immediately; then re-ramps from 0; ena=0 for 50 cycles -> duty frozen and pwm_out=0.
